// File: rtl/axi_lite_cmd_master_if.sv
// AXI4-Lite bus bundle used by axi_lite_cmd_master.
//
// Parameters:
//   ADDR_WIDTH  address width of awaddr/araddr
//   DATA_WIDTH  data width of wdata/rdata; wstrb is DATA_WIDTH/8 bits
//
// Channels: aw{addr,valid,ready}, w{data,strb,valid,ready}, b{resp,valid,ready},
//           ar{addr,valid,ready}, r{data,resp,valid,ready}. No prot signals.
// Modports: master (drives addresses, data, valids and b/r readies),
//           slave  (the mirror image).
interface axi_lite_cmd_master_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) ();
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic                    awvalid;
    logic                    awready;

    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;

    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;

    logic [ADDR_WIDTH-1:0]   araddr;
    logic                    arvalid;
    logic                    arready;

    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input  bresp, bvalid, output bready,
        output araddr, arvalid, input arready,
        input  rdata, rresp, rvalid, output rready
    );

    modport slave (
        input  awaddr, awvalid, output awready,
        input  wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input  araddr, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/axi_lite_cmd_master.sv
// Single-outstanding AXI4-Lite master. Accepts one command on a valid/ready
// port, runs it as an AXI-Lite write or read, and returns the result on a
// valid/ready response port. A per-transaction timeout turns a hung slave
// into an error response (resp 2'b10, rsp_timeout 1, rdata 0).
//
// Parameters:
//   ADDR_WIDTH  AXI address width
//   DATA_WIDTH  data width, 32 or 64 only
//   TIMEOUT     max cycles from command accept to AXI completion; 0 disables
//
// Ports:
//   aclk, areset                       clock, async active-high reset
//   cmd_valid/cmd_ready, cmd_write,
//   cmd_addr, cmd_wdata, cmd_wstrb     command port
//   rsp_valid/rsp_ready, rsp_write,
//   rsp_rdata, rsp_resp, rsp_timeout   response port
//   busy                               high whenever not idle
//   m_axi_lite                         AXI4-Lite master bus
module axi_lite_cmd_master #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic                    rsp_write,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]              rsp_resp,
    output logic                    rsp_timeout,
    output logic                    busy,
    axi_lite_cmd_master_if.master   m_axi_lite
);

    generate
        if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_width
            $error("axi_lite_cmd_master: DATA_WIDTH must be 32 or 64");
        end
    endgenerate

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int LSB        = $clog2(STRB_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK =
        ~((ADDR_WIDTH'(1) << LSB) - ADDR_WIDTH'(1));

    // The counter can run one step past TIMEOUT-1 when a handshake lands
    // exactly on the last allowed cycle, so leave headroom above TIMEOUT.
    localparam int CNT_WIDTH = $clog2(TIMEOUT + 2) + 1;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST =
        (TIMEOUT == 0) ? '0 : CNT_WIDTH'(TIMEOUT - 1);
    localparam bit TIMEOUT_EN = (TIMEOUT != 0);

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_RESP,
        RSP
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic                    abort;
    logic                    aw_sent;
    logic                    w_sent;
    logic [CNT_WIDTH-1:0]    cnt;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [STRB_WIDTH-1:0]   wstrb_q;
    logic                    write_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic [1:0]              resp_q;
    logic                    timeout_q;

    logic aw_hs;
    logic w_hs;
    logic b_hs;
    logic ar_hs;
    logic r_hs;
    logic expire;

    // Every bus and response output is a decode of registered state, so no
    // input ready/valid ever reaches an output combinationally.
    assign m_axi_lite.awaddr  = addr_q;
    assign m_axi_lite.awvalid = (state == WR_REQ) && !aw_sent;
    assign m_axi_lite.wdata   = wdata_q;
    assign m_axi_lite.wstrb   = wstrb_q;
    assign m_axi_lite.wvalid  = (state == WR_REQ) && !w_sent;
    assign m_axi_lite.bready  = (state == WR_RESP);
    assign m_axi_lite.araddr  = addr_q;
    assign m_axi_lite.arvalid = (state == RD_REQ);
    assign m_axi_lite.rready  = (state == RD_RESP);

    assign cmd_ready   = (state == IDLE);
    assign rsp_valid   = (state == RSP);
    assign busy        = (state != IDLE);
    assign rsp_write   = write_q;
    assign rsp_rdata   = rdata_q;
    assign rsp_resp    = resp_q;
    assign rsp_timeout = timeout_q;

    assign aw_hs  = m_axi_lite.awvalid && m_axi_lite.awready;
    assign w_hs   = m_axi_lite.wvalid  && m_axi_lite.wready;
    assign b_hs   = m_axi_lite.bready  && m_axi_lite.bvalid;
    assign ar_hs  = m_axi_lite.arvalid && m_axi_lite.arready;
    assign r_hs   = m_axi_lite.rready  && m_axi_lite.rvalid;
    // ">=" rather than "==" so a wait state entered at TIMEOUT still aborts.
    assign expire = TIMEOUT_EN && (cnt >= CNT_LAST);

    // Next-state decode. A handshake always wins over the timeout in the
    // same cycle, so the last allowed cycle can still complete normally.
    always_comb begin
        state_next = state;
        abort      = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    state_next = cmd_write ? WR_REQ : RD_REQ;
                end
            end
            WR_REQ: begin
                if ((aw_sent || aw_hs) && (w_sent || w_hs)) begin
                    state_next = WR_RESP;
                end else if (expire) begin
                    state_next = RSP;
                    abort      = 1'b1;
                end
            end
            WR_RESP: begin
                if (b_hs) begin
                    state_next = RSP;
                end else if (expire) begin
                    state_next = RSP;
                    abort      = 1'b1;
                end
            end
            RD_REQ: begin
                if (ar_hs) begin
                    state_next = RD_RESP;
                end else if (expire) begin
                    state_next = RSP;
                    abort      = 1'b1;
                end
            end
            RD_RESP: begin
                if (r_hs) begin
                    state_next = RSP;
                end else if (expire) begin
                    state_next = RSP;
                    abort      = 1'b1;
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register plus command/response capture. Response fields are
    // cleared on accept so a write reports rdata 0, and overwritten with the
    // timeout error if the transaction is aborted.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state     <= IDLE;
            aw_sent   <= 1'b0;
            w_sent    <= 1'b0;
            cnt       <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            write_q   <= 1'b0;
            rdata_q   <= '0;
            resp_q    <= 2'b00;
            timeout_q <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        addr_q    <= cmd_addr & ALIGN_MASK;
                        wdata_q   <= cmd_wdata;
                        wstrb_q   <= cmd_wstrb;
                        write_q   <= cmd_write;
                        cnt       <= '0;
                        aw_sent   <= 1'b0;
                        w_sent    <= 1'b0;
                        rdata_q   <= '0;
                        resp_q    <= 2'b00;
                        timeout_q <= 1'b0;
                    end
                end
                WR_REQ: begin
                    cnt <= cnt + CNT_WIDTH'(1);
                    if (aw_hs) aw_sent <= 1'b1;
                    if (w_hs)  w_sent  <= 1'b1;
                end
                WR_RESP: begin
                    cnt <= cnt + CNT_WIDTH'(1);
                    if (b_hs) resp_q <= m_axi_lite.bresp;
                end
                RD_REQ: begin
                    cnt <= cnt + CNT_WIDTH'(1);
                end
                RD_RESP: begin
                    cnt <= cnt + CNT_WIDTH'(1);
                    if (r_hs) begin
                        rdata_q <= m_axi_lite.rdata;
                        resp_q  <= m_axi_lite.rresp;
                    end
                end
                default: ;
            endcase
            if (abort) begin
                resp_q    <= 2'b10;
                timeout_q <= 1'b1;
                rdata_q   <= '0;
            end
        end
    end

endmodule
